vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the fixed 640x480 sync block.
- Derives a pixel-rate enable from the system clock and scans horizontal and vertical counters over any timing set.
- Produces polarity-configurable syncs, video-active, pixel coordinates, line/frame end strobes and a frame counter.
- Sits between the system clock and the pixel-generation/game-render logic.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BACK, 48, horizontal back porch (ticks)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel; must be >=1
- HSYNC_POL, 0, active level of h_sync (0 = active-low)
- VSYNC_POL, 0, active level of v_sync
- CNT_W, 11, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- FCNT_W, 8, frame counter width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  run control; low = hold in idle
- pixel_tick  out  1  one-clock pulse, once per CLK_DIV clocks
- pixel_x  out  CNT_W  horizontal count
- pixel_y  out  CNT_W  vertical count
- h_sync  out  1  horizontal sync at HSYNC_POL active level
- v_sync  out  1  vertical sync at VSYNC_POL active level
- video_on  out  1  current position is visible
- line_end  out  1  pulse on the tick of the last pixel of a line
- frame_end  out  1  pulse on the tick of the last pixel of a frame
- frame_count  out  FCNT_W  completed-frame counter, wraps

Behaviour:
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL is the same sum for V (default 525).
- Divider counter runs 0..CLK_DIV-1. pixel_tick = running && div==CLK_DIV-1. CLK_DIV=1 gives a tick every cycle.
- On pixel_tick:
  - pixel_x = (pixel_x==H_TOTAL-1) ? 0 : pixel_x+1.
  - pixel_y advances only when pixel_x==H_TOTAL-1, and wraps from V_TOTAL-1 to 0.
- Counters hold on non-tick cycles.
- h_sync is active iff H_DISPLAY+H_FRONT <= pixel_x <= H_DISPLAY+H_FRONT+H_SYNC-1. v_sync uses the same rule on pixel_y with the V parameters.
- Sync outputs are registered. They change on the same clock edge as the counters, so they are always consistent with pixel_x/pixel_y.
- video_on = running && pixel_x < H_DISPLAY && pixel_y < V_DISPLAY (strict less-than). It is registered alongside the counters.
- line_end = pixel_tick && pixel_x==H_TOTAL-1 (combinational).
- frame_end = line_end && pixel_y==V_TOTAL-1.
- frame_count increments on frame_end.
- Reset (async, any time including mid-frame):
  - div, pixel_x, pixel_y, frame_count = 0
  - running = 0
  - h_sync = ~HSYNC_POL, v_sync = ~VSYNC_POL
  - video_on = 0, all strobes 0
- enable low (sampled synchronously): same idle state as reset, except frame_count holds.
- enable rising: running=1 from the next clock. The position is (0,0) and video_on=1. The first pixel_tick arrives CLK_DIV clocks after running rises.
- enable dropping mid-line: idle on the next clock. No partial-line completion.

Decomposition:
- Package vga_timing_pkg holds:
  - mode constants: VGA_640x480_60 (values above, CLK_DIV 4 @100 MHz); SVGA_800x600_72 (800/56/120/64, 600/37/6/23, positive polarity, CLK_DIV 2)
  - a function computing the required CNT_W from a total.
- One sub-module: pixel_tick_gen (parametrised divider with enable and clear).

Test Plan:
- Defaults, enable=1 after reset: pixel_tick every 4 clocks; line_end every 3200 clocks; frame_end every 1,680,000 clocks; frame_count 0->1 after the first frame.
- Defaults, hsync window: h_sync low exactly while pixel_x in 656..751 (96 ticks = 384 clocks). v_sync low only for pixel_y 490..491. video_on=0 at pixel_x=640 and pixel_y=480.
- Small config (H 8/2/2/2, V 4/1/1/1, CLK_DIV=1, HSYNC_POL=VSYNC_POL=1):
  - pixel_x wraps 13->0, pixel_y wraps 6->0
  - h_sync high for x=10..11; v_sync high for y=5
  - frame_end every 98 clocks
- Async reset asserted mid-frame (x=300, y=200), released 3 clocks later: all outputs return to reset values immediately. Scan restarts at (0,0) with video_on=1 once enable is seen.
- enable deasserted at x=100: next clock pixel_x=0, video_on=0, syncs inactive, frame_count unchanged. Re-enable gives the first tick CLK_DIV clocks later.
- frame_count wrap with FCNT_W=2, small config: after 4 frames frame_count returns to 0, coincident with frame_end.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: standard mode sets and counter sizing helpers.
// The mode constants feed the vga_timing_gen parameters.
package vga_timing_pkg;

    typedef struct packed {
        int   h_display;
        int   h_front;
        int   h_sync;
        int   h_back;
        int   v_display;
        int   v_front;
        int   v_sync;
        int   v_back;
        int   clk_div;
        logic hsync_pol;
        logic vsync_pol;
    } vga_mode_t;

    // 640x480 @ 60 Hz from a 100 MHz system clock.
    localparam vga_mode_t VGA_640x480_60 =
        '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, 1'b0};

    // 800x600 @ 72 Hz with a 2:1 clock divider.
    localparam vga_mode_t SVGA_800x600_72 =
        '{800, 56, 120, 64, 600, 37, 6, 23, 2, 1'b1, 1'b1};

    // Bits needed to hold the values 0..total-1, never less than one.
    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    function automatic int h_total(input vga_mode_t m);
        return m.h_display + m.h_front + m.h_sync + m.h_back;
    endfunction

    function automatic int v_total(input vga_mode_t m);
        return m.v_display + m.v_front + m.v_sync + m.v_back;
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate divider: one-clock tick every CLK_DIV clocks while enabled.
// A clear returns the phase to zero so a restart always sees a full period.
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int               DIV_W    = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (clear) begin
            div <= '0;
        end else if (enable) begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

    assign tick = enable && (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel divider, H/V scan counters,
// registered syncs and video_on, line/frame strobes and a frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = 11,
    parameter int FCNT_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    output logic              pixel_tick,
    output logic [CNT_W-1:0]  pixel_x,
    output logic [CNT_W-1:0]  pixel_y,
    output logic              h_sync,
    output logic              v_sync,
    output logic              video_on,
    output logic              line_end,
    output logic              frame_end,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VISIBLE    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VISIBLE    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic             running;
    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_next;

    // The divider only counts once the scan is running and drops back to
    // phase zero as soon as enable is seen low.
    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick_gen (
        .clock (clock),
        .reset (reset),
        .enable(running),
        .clear (!enable),
        .tick  (pixel_tick)
    );

    assign line_end  = pixel_tick && (pixel_x == H_LAST);
    assign frame_end = line_end && (pixel_y == V_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        x_next = pixel_x;
        y_next = pixel_y;
        if (!running) begin
            x_next = '0;
            y_next = '0;
        end else if (pixel_tick) begin
            if (line_end) begin
                x_next = '0;
                y_next = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
            end else begin
                x_next = pixel_x + 1'b1;
            end
        end
    end

    // Syncs and video_on are decoded from the next position so they update on
    // the same edge as the counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            running     <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            h_sync      <= !HSYNC_POL;
            v_sync      <= !VSYNC_POL;
            video_on    <= 1'b0;
            frame_count <= '0;
        end else if (!enable) begin
            running  <= 1'b0;
            pixel_x  <= '0;
            pixel_y  <= '0;
            h_sync   <= !HSYNC_POL;
            v_sync   <= !VSYNC_POL;
            video_on <= 1'b0;
        end else begin
            running  <= 1'b1;
            pixel_x  <= x_next;
            pixel_y  <= y_next;
            h_sync   <= (x_next >= H_SYNC_FIRST && x_next <= H_SYNC_LAST) ? HSYNC_POL : !HSYNC_POL;
            v_sync   <= (y_next >= V_SYNC_FIRST && y_next <= V_SYNC_LAST) ? VSYNC_POL : !VSYNC_POL;
            video_on <= (x_next < H_VISIBLE) && (y_next < V_VISIBLE);
            if (frame_end) begin
                frame_count <= frame_count + FCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every clock against a
// closed-form raster model, plus vector tables and directed corner sequences.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        tick, hs, vs, von, le, fe;
        logic [7:0]  fc;
    } obs_t;

    typedef struct {
        int hd, hf, hsy, hb, vd, vf, vsy, vb, div;
        bit hpol, vpol;
        int fw;
    } cfg_t;

    typedef struct {
        int   inst;
        obs_t exp;
    } sb_t;

    // flags = {h_sync, v_sync, video_on, line_end, frame_end}
    typedef struct {
        int         k;
        int         x;
        int         y;
        logic [4:0] flags;
        int         fc;
    } vec_t;

    logic       clock = 1'b0;
    logic [2:0] rst   = 3'b000;
    logic [2:0] en    = 3'b000;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clock) cyc++;

    // A: default 640x480 timing
    logic        a_tick, a_hs, a_vs, a_von, a_le, a_fe;
    logic [10:0] a_x, a_y;
    logic [7:0]  a_fc;
    vga_timing_gen #(
        .H_DISPLAY(VGA_640x480_60.h_display), .H_FRONT(VGA_640x480_60.h_front),
        .H_SYNC(VGA_640x480_60.h_sync), .H_BACK(VGA_640x480_60.h_back),
        .V_DISPLAY(VGA_640x480_60.v_display), .V_FRONT(VGA_640x480_60.v_front),
        .V_SYNC(VGA_640x480_60.v_sync), .V_BACK(VGA_640x480_60.v_back),
        .CLK_DIV(VGA_640x480_60.clk_div), .HSYNC_POL(VGA_640x480_60.hsync_pol),
        .VSYNC_POL(VGA_640x480_60.vsync_pol), .CNT_W(11), .FCNT_W(8)
    ) dut_a (
        .clock(clock), .reset(rst[0]), .enable(en[0]), .pixel_tick(a_tick),
        .pixel_x(a_x), .pixel_y(a_y), .h_sync(a_hs), .v_sync(a_vs), .video_on(a_von),
        .line_end(a_le), .frame_end(a_fe), .frame_count(a_fc)
    );

    // B: short lines, default vertical timing, one clock per pixel
    logic        b_tick, b_hs, b_vs, b_von, b_le, b_fe;
    logic [10:0] b_x, b_y;
    logic [7:0]  b_fc;
    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
        .CLK_DIV(1), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(11), .FCNT_W(8)
    ) dut_b (
        .clock(clock), .reset(rst[1]), .enable(en[1]), .pixel_tick(b_tick),
        .pixel_x(b_x), .pixel_y(b_y), .h_sync(b_hs), .v_sync(b_vs), .video_on(b_von),
        .line_end(b_le), .frame_end(b_fe), .frame_count(b_fc)
    );

    // C: tiny raster, positive syncs, 2-bit frame counter
    logic       c_tick, c_hs, c_vs, c_von, c_le, c_fe;
    logic [3:0] c_x, c_y;
    logic [1:0] c_fc;
    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(4), .FCNT_W(2)
    ) dut_c (
        .clock(clock), .reset(rst[2]), .enable(en[2]), .pixel_tick(c_tick),
        .pixel_x(c_x), .pixel_y(c_y), .h_sync(c_hs), .v_sync(c_vs), .video_on(c_von),
        .line_end(c_le), .frame_end(c_fe), .frame_count(c_fc)
    );

    cfg_t cfg [3];
    bit   run_m [3];
    int   k_m [3];
    int   fcb_m [3];
    int   fch_m [3];
    sb_t  sbq [$];
    vec_t vec [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_obs(input int i, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL sb_inst%0d @cyc %0d: got x=%0d y=%0d tick/hs/vs/von/le/fe=%b fc=%0d, expected x=%0d y=%0d tick/hs/vs/von/le/fe=%b fc=%0d",
                     i, cyc, act.x, act.y, {act.tick, act.hs, act.vs, act.von, act.le, act.fe}, act.fc,
                     exp.x, exp.y, {exp.tick, exp.hs, exp.vs, exp.von, exp.le, exp.fe}, exp.fc);
        end
    endtask

    // Closed-form raster: position follows from clocks elapsed since the scan started.
    function automatic obs_t model(input int i);
        obs_t o;
        cfg_t c;
        int   ht, vt, t, x, y;
        c = cfg[i];
        o = '0;
        if (!run_m[i]) begin
            o.hs = !c.hpol;
            o.vs = !c.vpol;
            o.fc = 8'(fch_m[i]);
            return o;
        end
        ht     = c.hd + c.hf + c.hsy + c.hb;
        vt     = c.vd + c.vf + c.vsy + c.vb;
        t      = k_m[i] / c.div;
        x      = t % ht;
        y      = (t / ht) % vt;
        o.x    = 16'(x);
        o.y    = 16'(y);
        o.tick = (k_m[i] % c.div) == c.div - 1;
        o.hs   = (x >= c.hd + c.hf && x < c.hd + c.hf + c.hsy) ? c.hpol : !c.hpol;
        o.vs   = (y >= c.vd + c.vf && y < c.vd + c.vf + c.vsy) ? c.vpol : !c.vpol;
        o.von  = (x < c.hd) && (y < c.vd);
        o.le   = o.tick && (x == ht - 1);
        o.fe   = o.le && (y == vt - 1);
        o.fc   = 8'((fcb_m[i] + t / (ht * vt)) % (1 << c.fw));
        return o;
    endfunction

    function automatic obs_t actual(input int i);
        obs_t o;
        case (i)
            0: o = '{x:16'(a_x), y:16'(a_y), tick:a_tick, hs:a_hs, vs:a_vs, von:a_von, le:a_le, fe:a_fe, fc:8'(a_fc)};
            1: o = '{x:16'(b_x), y:16'(b_y), tick:b_tick, hs:b_hs, vs:b_vs, von:b_von, le:b_le, fe:b_fe, fc:8'(b_fc)};
            2: o = '{x:16'(c_x), y:16'(c_y), tick:c_tick, hs:c_hs, vs:c_vs, von:c_von, le:c_le, fe:c_fe, fc:8'(c_fc)};
            default: o = '0;
        endcase
        return o;
    endfunction

    // Scoreboard: expectations queued at each edge from the driven inputs,
    // compared against the DUT 1 time unit later.
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            obs_t cur;
            if (rst[i]) begin
                run_m[i] = 1'b0;
                fch_m[i] = 0;
            end else if (en[i]) begin
                if (!run_m[i]) begin
                    run_m[i] = 1'b1;
                    k_m[i]   = 0;
                    fcb_m[i] = fch_m[i];
                end else begin
                    k_m[i]++;
                end
            end else if (run_m[i]) begin
                cur      = model(i);
                fch_m[i] = int'(cur.fc);
                run_m[i] = 1'b0;
            end
            sbq.push_back('{i, model(i)});
        end
        #1;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            check_obs(e.inst, actual(e.inst), e.exp);
        end
    end

    initial begin
        int n, t0, hs_cnt, hs_min, hs_max, vs_cnt, vs_min, vs_max;
        bit seen480;

        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, 1'b0, 8};
        cfg[1] = '{8, 2, 2, 2, 480, 10, 2, 33, 1, 1'b0, 1'b0, 8};
        cfg[2] = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 1'b1, 1'b1, 2};
        for (int i = 0; i < 3; i++) begin
            run_m[i] = 1'b0; k_m[i] = 0; fcb_m[i] = 0; fch_m[i] = 0;
        end

        // Small-config vectors, k = clocks since the scan started.
        vec[0]  = '{0,   0,  0, 5'b00100, 0};
        vec[1]  = '{7,   7,  0, 5'b00100, 0};
        vec[2]  = '{8,   8,  0, 5'b00000, 0};
        vec[3]  = '{10,  10, 0, 5'b10000, 0};
        vec[4]  = '{11,  11, 0, 5'b10000, 0};
        vec[5]  = '{12,  12, 0, 5'b00000, 0};
        vec[6]  = '{13,  13, 0, 5'b00010, 0};
        vec[7]  = '{14,  0,  1, 5'b00100, 0};
        vec[8]  = '{69,  13, 4, 5'b00010, 0};
        vec[9]  = '{70,  0,  5, 5'b01000, 0};
        vec[10] = '{83,  13, 5, 5'b01010, 0};
        vec[11] = '{84,  0,  6, 5'b00000, 0};
        vec[12] = '{97,  13, 6, 5'b00011, 0};
        vec[13] = '{98,  0,  0, 5'b00100, 1};
        vec[14] = '{391, 13, 6, 5'b00011, 3};
        vec[15] = '{392, 0,  0, 5'b00100, 0};

        #2 rst = 3'b111;
        repeat (2) @(negedge clock);
        check("rst_a_x", a_x, 0);
        check("rst_a_hs", a_hs, 1);
        check("rst_a_von", a_von, 0);
        check("rst_b_vs", b_vs, 1);
        check("rst_c_hs", c_hs, 0);
        check("rst_c_vs", c_vs, 0);
        rst = 3'b000;
        @(negedge clock);

        // A: line period, h_sync window, tick period
        en[0] = 1'b1;
        n = 0;
        while (!a_le && n < 4000) begin @(negedge clock); n++; end
        check("a_first_line_end", a_le, 1);
        t0 = cyc; hs_cnt = 0; hs_min = 99999; hs_max = -1;
        @(negedge clock);
        n = 0;
        while (!a_le && n < 4000) begin
            if (!a_hs) begin
                hs_cnt++;
                if (int'(a_x) < hs_min) hs_min = int'(a_x);
                if (int'(a_x) > hs_max) hs_max = int'(a_x);
            end
            @(negedge clock); n++;
        end
        check("a_line_period", cyc - t0, 3200);
        check("a_hsync_clocks", hs_cnt, 384);
        check("a_hsync_first_x", hs_min, 656);
        check("a_hsync_last_x", hs_max, 751);
        @(negedge clock);
        n = 0;
        while (!a_tick && n < 10) begin @(negedge clock); n++; end
        t0 = cyc;
        @(negedge clock);
        n = 0;
        while (!a_tick && n < 10) begin @(negedge clock); n++; end
        check("a_tick_period", cyc - t0, 4);
        n = 0;
        while (a_x != 11'd639 && n < 4000) begin @(negedge clock); n++; end
        check("a_reach_x639", a_x, 639);
        check("a_von_x639", a_von, 1);
        n = 0;
        while (a_x != 11'd640 && n < 10) begin @(negedge clock); n++; end
        check("a_reach_x640", a_x, 640);
        check("a_von_x640", a_von, 0);

        // A: enable dropped at x=100, then re-enabled
        n = 0;
        while (a_x != 11'd100 && n < 4000) begin @(negedge clock); n++; end
        check("a_reach_x100", a_x, 100);
        en[0] = 1'b0;
        @(negedge clock);
        check("a_drop_x", a_x, 0);
        check("a_drop_von", a_von, 0);
        check("a_drop_hs", a_hs, 1);
        check("a_drop_vs", a_vs, 1);
        check("a_drop_fc", a_fc, 0);
        en[0] = 1'b1;
        @(negedge clock);
        check("a_restart_von", a_von, 1);
        n = 0;
        while (a_x != 11'd1 && n < 20) begin @(negedge clock); n++; end
        check("a_restart_first_advance", n, 4);

        // A: async reset mid-line at x=300
        n = 0;
        while (a_x != 11'd300 && n < 2000) begin @(negedge clock); n++; end
        check("a_reach_x300", a_x, 300);
        rst[0] = 1'b1; run_m[0] = 1'b0; fch_m[0] = 0;
        #1;
        check("a_arst_x", a_x, 0);
        check("a_arst_von", a_von, 0);
        check("a_arst_hs", a_hs, 1);
        check("a_arst_tick", a_tick, 0);
        repeat (3) @(negedge clock);
        rst[0] = 1'b0;
        @(negedge clock);
        check("a_rerun_x", a_x, 0);
        check("a_rerun_von", a_von, 1);
        en[0] = 1'b0;

        // B: async reset mid-frame at (3,200), then a full frame
        en[1] = 1'b1;
        n = 0;
        while (!(b_x == 11'd3 && b_y == 11'd200) && n < 4000) begin @(negedge clock); n++; end
        check("b_reach_y200", b_y, 200);
        rst[1] = 1'b1; run_m[1] = 1'b0; fch_m[1] = 0;
        #1;
        check("b_arst_y", b_y, 0);
        check("b_arst_x", b_x, 0);
        check("b_arst_vs", b_vs, 1);
        repeat (3) @(negedge clock);
        rst[1] = 1'b0;
        @(negedge clock);
        check("b_rerun_y", b_y, 0);
        check("b_rerun_von", b_von, 1);
        vs_cnt = 0; vs_min = 99999; vs_max = -1; seen480 = 1'b0;
        n = 0;
        while (!b_fe && n < 8000) begin
            if (!b_vs) begin
                vs_cnt++;
                if (int'(b_y) < vs_min) vs_min = int'(b_y);
                if (int'(b_y) > vs_max) vs_max = int'(b_y);
            end
            if (b_y == 11'd480 && !seen480) begin
                seen480 = 1'b1;
                check("b_von_y480", b_von, 0);
            end
            @(negedge clock); n++;
        end
        check("b_frame_end_seen", b_fe, 1);
        check("b_vsync_clocks", vs_cnt, 28);
        check("b_vsync_first_y", vs_min, 490);
        check("b_vsync_last_y", vs_max, 491);
        t0 = cyc;
        @(negedge clock);
        check("b_fc_after_frame", b_fc, 1);
        n = 0;
        while (!b_fe && n < 8000) begin @(negedge clock); n++; end
        check("b_frame_period", cyc - t0, 7350);
        en[1] = 1'b0;

        // C: vector table over four frames, including frame counter wrap
        en[2] = 1'b1;
        for (int j = 0; j < 16; j++) begin
            n = 0;
            while (!(run_m[2] && k_m[2] == vec[j].k) && n < 500) begin @(negedge clock); n++; end
            check($sformatf("c_vec%0d_reached", j), n < 500, 1);
            check($sformatf("c_vec%0d_x", j), c_x, vec[j].x);
            check($sformatf("c_vec%0d_y", j), c_y, vec[j].y);
            check($sformatf("c_vec%0d_flags", j), {c_hs, c_vs, c_von, c_le, c_fe}, vec[j].flags);
            check($sformatf("c_vec%0d_fc", j), c_fc, vec[j].fc);
        end
        en[2] = 1'b0;

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
